// File: rtl/csr_seg_pkg.sv
// csr_seg_pkg: shared definitions for the CSR write segment-register chain.
//   CSR_DW / CSR_AW  default CSR data and address widths
//   CSR_MAX_DEPTH    largest stage count the forwarding search supports
//   csr_wr_t         one in-flight CSR write record {we, addr, data}
//   csr_youngest_idx priority search returning the youngest matching stage
package csr_seg_pkg;

    localparam int unsigned CSR_DW        = 32;
    localparam int unsigned CSR_AW        = 12;
    localparam int unsigned CSR_MAX_DEPTH = 64;

    typedef struct packed {
        logic              we;
        logic [CSR_AW-1:0] addr;
        logic [CSR_DW-1:0] data;
    } csr_wr_t;

    // Lowest set bit wins: stage 0 is the youngest write. Returns -1 if none.
    function automatic int csr_youngest_idx(input logic [CSR_MAX_DEPTH-1:0] match);
        int idx;
        idx = -1;
        for (int unsigned i = CSR_MAX_DEPTH; i > 0; i--) begin
            if (match[i-1]) idx = int'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/csr_seg_stage.sv
// csr_seg_stage: one segment register of the CSR write chain.
//   clk, rst               clock, synchronous active-high reset
//   bubble_i               hold the current contents (beats flush_i)
//   flush_i                clear the stage to an empty write
//   we_i, addr_i, data_i   incoming write from the previous stage / EX
//   we_o, addr_o, data_o   registered stage contents
module csr_seg_stage
    import csr_seg_pkg::*;
#(
    parameter int unsigned DW = CSR_DW,
    parameter int unsigned AW = CSR_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bubble_i,
    input  logic          flush_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o
);

    logic          we_q,   we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    // A flush arriving together with a bubble is dropped, not remembered.
    always_comb begin
        we_d   = we_q;
        addr_d = addr_q;
        data_d = data_q;
        if (bubble_i) begin
            we_d   = we_q;
        end else if (flush_i) begin
            we_d   = 1'b0;
            addr_d = '0;
            data_d = '0;
        end else begin
            we_d   = we_i;
            addr_d = addr_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/csr_seg_pipe.sv
// csr_seg_pipe: DEPTH-stage segment-register chain carrying CSR writes from
// EX to WB, with per-stage bubble/flush and a youngest-write forwarding lookup.
//   clk, rst                                  clock, synchronous active-high reset
//   bubble[i], flush[i]                       hold / clear stage i
//   csr_we_EX, csr_addr_EX, csr_data_EX       write entering stage 0
//   csr_we_out, csr_addr_out, csr_data_out    last stage, towards WB
//   stage_we                                  write enable of every stage
//   fwd_addr -> fwd_hit, fwd_data             combinational forwarding lookup
//   flush_cnt                                 flushed valid writes (saturating)
// Optional: define CSR_SEG_FLUSH_CNT_EN to build the flush counter; otherwise
// flush_cnt is tied to 0. DEPTH must lie in 1..CSR_MAX_DEPTH.
module csr_seg_pipe
    import csr_seg_pkg::*;
#(
    parameter int unsigned DW    = CSR_DW,
    parameter int unsigned AW    = CSR_AW,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] bubble,
    input  logic [DEPTH-1:0] flush,
    input  logic             csr_we_EX,
    input  logic [AW-1:0]    csr_addr_EX,
    input  logic [DW-1:0]    csr_data_EX,
    output logic             csr_we_out,
    output logic [AW-1:0]    csr_addr_out,
    output logic [DW-1:0]    csr_data_out,
    output logic [DEPTH-1:0] stage_we,
    input  logic [AW-1:0]    fwd_addr,
    output logic             fwd_hit,
    output logic [DW-1:0]    fwd_data,
    output logic [31:0]      flush_cnt
);

    logic          st_we   [DEPTH];
    logic [AW-1:0] st_addr [DEPTH];
    logic [DW-1:0] st_data [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic          in_we;
        logic [AW-1:0] in_addr;
        logic [DW-1:0] in_data;

        if (g == 0) begin : g_head
            assign in_we   = csr_we_EX;
            assign in_addr = csr_addr_EX;
            assign in_data = csr_data_EX;
        end else begin : g_body
            assign in_we   = st_we[g-1];
            assign in_addr = st_addr[g-1];
            assign in_data = st_data[g-1];
        end

        csr_seg_stage #(
            .DW(DW),
            .AW(AW)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .bubble_i(bubble[g]),
            .flush_i (flush[g]),
            .we_i    (in_we),
            .addr_i  (in_addr),
            .data_i  (in_data),
            .we_o    (st_we[g]),
            .addr_o  (st_addr[g]),
            .data_o  (st_data[g])
        );

        assign stage_we[g] = st_we[g];
    end

    assign csr_we_out   = st_we[DEPTH-1];
    assign csr_addr_out = st_addr[DEPTH-1];
    assign csr_data_out = st_data[DEPTH-1];

    // Forwarding: only valid stages can match; the EX input is not searched.
    logic [CSR_MAX_DEPTH-1:0] match_pad;
    int                       hit_idx;

    always_comb begin
        match_pad = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match_pad[i] = st_we[i] && (st_addr[i] == fwd_addr);
        end
        hit_idx  = csr_youngest_idx(match_pad);
        fwd_hit  = (hit_idx >= 0);
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (int'(i) == hit_idx) fwd_data = st_data[i];
        end
    end

`ifdef CSR_SEG_FLUSH_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] kill_n;
    logic [32:0] cnt_sum;

    // A flush only kills a write when the stage is not bubbled.
    always_comb begin
        kill_n = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (flush[i] && !bubble[i] && st_we[i]) kill_n = kill_n + 32'd1;
        end
        cnt_sum = {1'b0, cnt_q} + {1'b0, kill_n};
        cnt_d   = cnt_sum[32] ? '1 : cnt_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign flush_cnt = cnt_q;
`else
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_csr_seg_pipe.sv
module tb_csr_seg_pipe;
    import csr_seg_pkg::*;

    localparam int D = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [D-1:0]  bubble, flush;
    logic          csr_we_EX;
    logic [11:0]   csr_addr_EX;
    logic [31:0]   csr_data_EX;
    logic          csr_we_out;
    logic [11:0]   csr_addr_out;
    logic [31:0]   csr_data_out;
    logic [D-1:0]  stage_we;
    logic [11:0]   fwd_addr;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [31:0]   flush_cnt;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    csr_seg_pipe #(
        .DW(32),
        .AW(12),
        .DEPTH(D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bubble      (bubble),
        .flush       (flush),
        .csr_we_EX   (csr_we_EX),
        .csr_addr_EX (csr_addr_EX),
        .csr_data_EX (csr_data_EX),
        .csr_we_out  (csr_we_out),
        .csr_addr_out(csr_addr_out),
        .csr_data_out(csr_data_out),
        .stage_we    (stage_we),
        .fwd_addr    (fwd_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .flush_cnt   (flush_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: an array of write records shifted by the stage rules.
    csr_wr_t     mdl [D];
    longint      mdl_cnt;

    task automatic mdl_step(input bit r, input logic [D-1:0] b, input logic [D-1:0] f,
                            input csr_wr_t ex);
        csr_wr_t prev [D];
        prev = mdl;
        for (int i = 0; i < D; i++) begin
            if (r) mdl[i] = '0;
            else if (b[i]) mdl[i] = prev[i];
            else if (f[i]) begin
                if (prev[i].we) mdl_cnt++;
                mdl[i] = '0;
            end else mdl[i] = (i == 0) ? ex : prev[i-1];
        end
        if (r) mdl_cnt = 0;
        if (mdl_cnt > 64'hFFFF_FFFF) mdl_cnt = 64'hFFFF_FFFF;
    endtask

    // Walk from oldest to youngest so the youngest match is the one left standing.
    task automatic mdl_fwd(input logic [11:0] q, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        for (int i = D - 1; i >= 0; i--) begin
            if (mdl[i].we && mdl[i].addr == q) begin
                h = 1'b1;
                d = mdl[i].data;
            end
        end
    endtask

    typedef struct {
        bit           r;
        logic [D-1:0] b, f;
        logic         we;
        logic [11:0]  a;
        logic [31:0]  d;
        logic [11:0]  fa;
        logic         e_we;
        logic [11:0]  e_a;
        logic [31:0]  e_d;
        logic [D-1:0] e_sw;
        logic         e_hit;
        logic [31:0]  e_fd;
        logic [31:0]  e_cnt;
    } vec_t;

    vec_t tbl [13];

    task automatic apply(input bit r, input logic [D-1:0] b, input logic [D-1:0] f,
                         input logic we, input logic [11:0] a, input logic [31:0] d,
                         input logic [11:0] fa);
        rst = r; bubble = b; flush = f;
        csr_we_EX = we; csr_addr_EX = a; csr_data_EX = d; fwd_addr = fa;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        h;
        logic [31:0] fd;
        csr_wr_t     ex;
        logic [31:0] exp_cnt;

        //            r   bub    fl     we    addr     data          fwd      we_o  addr_o   data_o        s_we   hit   fwd_d         cnt
        tbl[0]  = '{1'b1, 2'b00, 2'b00, 1'b1, 12'h123, 32'h1234_5678, 12'h123, 1'b0, 12'h000, 32'h0,        2'b00, 1'b0, 32'h0,        32'd0};
        tbl[1]  = '{1'b0, 2'b00, 2'b00, 1'b1, 12'h300, 32'hDEAD_BEEF, 12'h300, 1'b0, 12'h000, 32'h0,        2'b01, 1'b1, 32'hDEAD_BEEF, 32'd0};
        tbl[2]  = '{1'b0, 2'b00, 2'b00, 1'b0, 12'h000, 32'h0,         12'h300, 1'b1, 12'h300, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'hDEAD_BEEF, 32'd0};
        tbl[3]  = '{1'b0, 2'b00, 2'b00, 1'b1, 12'h341, 32'hAAAA_0001, 12'h341, 1'b0, 12'h000, 32'h0,        2'b01, 1'b1, 32'hAAAA_0001, 32'd0};
        tbl[4]  = '{1'b0, 2'b01, 2'b01, 1'b1, 12'h111, 32'h5,         12'h341, 1'b1, 12'h341, 32'hAAAA_0001, 2'b11, 1'b1, 32'hAAAA_0001, 32'd0};
        tbl[5]  = '{1'b0, 2'b00, 2'b10, 1'b1, 12'h305, 32'h22,        12'h341, 1'b0, 12'h000, 32'h0,        2'b01, 1'b0, 32'h0,        32'd1};
        tbl[6]  = '{1'b0, 2'b00, 2'b00, 1'b1, 12'h305, 32'h11,        12'h305, 1'b1, 12'h305, 32'h22,       2'b11, 1'b1, 32'h11,       32'd1};
        tbl[7]  = '{1'b0, 2'b11, 2'b00, 1'b1, 12'h777, 32'h77,        12'h306, 1'b1, 12'h305, 32'h22,       2'b11, 1'b0, 32'h0,        32'd1};
        tbl[8]  = '{1'b0, 2'b00, 2'b00, 1'b0, 12'h305, 32'h22,        12'h305, 1'b1, 12'h305, 32'h11,       2'b10, 1'b1, 32'h11,       32'd1};
        tbl[9]  = '{1'b0, 2'b00, 2'b00, 1'b0, 12'h000, 32'h0,         12'h305, 1'b0, 12'h305, 32'h22,       2'b00, 1'b0, 32'h0,        32'd1};
        tbl[10] = '{1'b0, 2'b10, 2'b11, 1'b1, 12'h007, 32'h7,         12'h305, 1'b0, 12'h305, 32'h22,       2'b00, 1'b0, 32'h0,        32'd1};
        tbl[11] = '{1'b0, 2'b00, 2'b00, 1'b1, 12'h3FF, 32'hFFFF_FFFF, 12'h3FF, 1'b0, 12'h000, 32'h0,        2'b01, 1'b1, 32'hFFFF_FFFF, 32'd1};
        tbl[12] = '{1'b1, 2'b11, 2'b00, 1'b1, 12'h3FF, 32'h1,         12'h3FF, 1'b0, 12'h000, 32'h0,        2'b00, 1'b0, 32'h0,        32'd0};

        apply(1'b1, '0, '0, 1'b0, '0, '0, '0);
        apply(1'b1, '0, '0, 1'b0, '0, '0, '0);

        for (int k = 0; k < 13; k++) begin
            apply(tbl[k].r, tbl[k].b, tbl[k].f, tbl[k].we, tbl[k].a, tbl[k].d, tbl[k].fa);
`ifdef CSR_SEG_FLUSH_CNT_EN
            exp_cnt = tbl[k].e_cnt;
`else
            exp_cnt = 32'd0;
`endif
            chk($sformatf("vec%0d we_out", k),   64'(csr_we_out),   64'(tbl[k].e_we));
            chk($sformatf("vec%0d addr_out", k), 64'(csr_addr_out), 64'(tbl[k].e_a));
            chk($sformatf("vec%0d data_out", k), 64'(csr_data_out), 64'(tbl[k].e_d));
            chk($sformatf("vec%0d stage_we", k), 64'(stage_we),     64'(tbl[k].e_sw));
            chk($sformatf("vec%0d fwd_hit", k),  64'(fwd_hit),      64'(tbl[k].e_hit));
            chk($sformatf("vec%0d fwd_data", k), 64'(fwd_data),     64'(tbl[k].e_fd));
            chk($sformatf("vec%0d flush_cnt", k), 64'(flush_cnt),   64'(exp_cnt));
        end

        // Hand-written: reset asserted mid-stream while both stages hold writes.
        apply(1'b0, '0, '0, 1'b1, 12'h301, 32'hA1, 12'h301);
        apply(1'b0, '0, '0, 1'b1, 12'h302, 32'hA2, 12'h301);
        chk("loaded stage_we", 64'(stage_we), 64'(2'b11));
        chk("loaded fwd older", 64'(fwd_data), 64'hA1);
        apply(1'b1, 2'b11, 2'b11, 1'b1, 12'h303, 32'hA3, 12'h302);
        chk("midrst stage_we", 64'(stage_we), 64'(2'b00));
        chk("midrst data_out", 64'(csr_data_out), 64'h0);
        chk("midrst fwd_hit", 64'(fwd_hit), 64'h0);
        chk("midrst flush_cnt", 64'(flush_cnt), 64'h0);

        // Randomized traffic against the record-array model.
        for (int i = 0; i < D; i++) mdl[i] = '0;
        mdl_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            bit           r;
            logic [D-1:0] b, f;
            logic [11:0]  fa;
            r = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < D; i++) begin
                b[i] = ($urandom_range(0, 4) == 0);
                f[i] = ($urandom_range(0, 4) == 0);
            end
            ex.we   = ($urandom_range(0, 3) != 0);
            ex.addr = 12'h300 + 12'($urandom_range(0, 3));
            ex.data = $urandom;
            fa      = 12'h300 + 12'($urandom_range(0, 4));
            apply(r, b, f, ex.we, ex.addr, ex.data, fa);
            mdl_step(r, b, f, ex);
            mdl_fwd(fa, h, fd);
`ifdef CSR_SEG_FLUSH_CNT_EN
            exp_cnt = 32'(mdl_cnt);
`else
            exp_cnt = 32'd0;
`endif
            chk("rnd we_out",   64'(csr_we_out),   64'(mdl[D-1].we));
            chk("rnd addr_out", 64'(csr_addr_out), 64'(mdl[D-1].addr));
            chk("rnd data_out", 64'(csr_data_out), 64'(mdl[D-1].data));
            for (int i = 0; i < D; i++) chk($sformatf("rnd stage_we[%0d]", i), 64'(stage_we[i]), 64'(mdl[i].we));
            chk("rnd fwd_hit",  64'(fwd_hit),  64'(h));
            chk("rnd fwd_data", 64'(fwd_data), 64'(fd));
            chk("rnd flush_cnt", 64'(flush_cnt), 64'(exp_cnt));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
